// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared constants and types for the MIPS32 decode/execute boundary.
//   - ALU control codes (ALU_ADD..ALU_SRA), also consumed by the EX-stage ALU.
//   - Primary opcode and R-type funct encodings.
//   - Branch / jump kind encodings carried into EX.
//   - ctrl_t: the control bundle produced by decode and held in ID/EX.
// ---------------------------------------------------------------------------
package mips_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    // Primary opcodes, inst[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes, inst[5:0]
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;

    // Branch kind
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    // Jump kind
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JAL  = 2'b10;
    localparam logic [1:0] JMP_JR   = 2'b11;

    // Link register written by jal
    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [3:0]  aluc;
        logic        shift;
        logic [4:0]  sa;
        logic        aluimm;
        logic [31:0] imm32;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  rn;
        logic [1:0]  branch;
        logic [1:0]  jump;
        logic        illegal;
    } ctrl_t;

    // Sign-extend a 16-bit immediate to 32 bits.
    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage : mips_pkg

// File: rtl/alu_ctrl_dec.sv
// ---------------------------------------------------------------------------
// alu_ctrl_dec
//   Purely combinational decode of a MIPS32 instruction word into the EX
//   control bundle (ALU code, operand selects, memory/write-back enables,
//   destination register, extended immediate, branch/jump kind).
//   Unsupported opcodes/functs raise ctrl.illegal with every side-effecting
//   control left at zero and aluc at ALU_ADD.
//
// Ports:
//   inst  in  32     instruction word
//   ctrl  out ctrl_t decoded control bundle (ungated; rn==0 write
//                    suppression is applied by the pipeline register)
// ---------------------------------------------------------------------------
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;

    assign op    = inst[31:26];
    assign funct = inst[5:0];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign imm   = inst[15:0];

    // rs is read by the register file, not by this decoder.
    logic unused_rs;
    assign unused_rs = ^inst[25:21];

    always_comb begin
        ctrl        = '0;
        ctrl.aluc   = ALU_ADD;
        ctrl.sa     = inst[10:6];
        ctrl.imm32  = sext16(imm);
        ctrl.rn     = rt;

        case (op)
            OP_RTYPE: begin
                ctrl.rn   = rd;
                ctrl.wreg = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl.aluc = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.aluc = ALU_SUB;
                    FN_AND:          ctrl.aluc = ALU_AND;
                    FN_OR:           ctrl.aluc = ALU_OR;
                    FN_XOR:          ctrl.aluc = ALU_XOR;
                    FN_SLL: begin
                        ctrl.aluc  = ALU_SLL;
                        ctrl.shift = 1'b1;
                    end
                    FN_SRL: begin
                        ctrl.aluc  = ALU_SRL;
                        ctrl.shift = 1'b1;
                    end
                    FN_SRA: begin
                        ctrl.aluc  = ALU_SRA;
                        ctrl.shift = 1'b1;
                    end
                    FN_JR: begin
                        ctrl.jump = JMP_JR;
                        ctrl.wreg = 1'b0;
                    end
                    default: begin
                        ctrl.illegal = 1'b1;
                        ctrl.wreg    = 1'b0;
                    end
                endcase
            end

            OP_ADDI, OP_ADDIU: begin
                ctrl.aluc   = ALU_ADD;
                ctrl.aluimm = 1'b1;
                ctrl.wreg   = 1'b1;
            end

            OP_ANDI: begin
                ctrl.aluc   = ALU_AND;
                ctrl.aluimm = 1'b1;
                ctrl.imm32  = {16'h0000, imm};
                ctrl.wreg   = 1'b1;
            end

            OP_ORI: begin
                ctrl.aluc   = ALU_OR;
                ctrl.aluimm = 1'b1;
                ctrl.imm32  = {16'h0000, imm};
                ctrl.wreg   = 1'b1;
            end

            OP_XORI: begin
                ctrl.aluc   = ALU_XOR;
                ctrl.aluimm = 1'b1;
                ctrl.imm32  = {16'h0000, imm};
                ctrl.wreg   = 1'b1;
            end

            OP_LUI: begin
                // The ALU does the <<16; decode only zero-extends.
                ctrl.aluc   = ALU_LUI;
                ctrl.aluimm = 1'b1;
                ctrl.imm32  = {16'h0000, imm};
                ctrl.wreg   = 1'b1;
            end

            OP_LW: begin
                ctrl.aluc   = ALU_ADD;
                ctrl.aluimm = 1'b1;
                ctrl.wreg   = 1'b1;
                ctrl.m2reg  = 1'b1;
            end

            OP_SW: begin
                ctrl.aluc   = ALU_ADD;
                ctrl.aluimm = 1'b1;
                ctrl.wmem   = 1'b1;
            end

            OP_BEQ: begin
                // Equality is tested by subtracting rt from rs.
                ctrl.aluc   = ALU_SUB;
                ctrl.branch = BR_BEQ;
            end

            OP_BNE: begin
                ctrl.aluc   = ALU_SUB;
                ctrl.branch = BR_BNE;
            end

            OP_J: begin
                ctrl.jump = JMP_J;
            end

            OP_JAL: begin
                // The ALU forms the link address as pc+8 via an ADD.
                ctrl.aluc = ALU_ADD;
                ctrl.jump = JMP_JAL;
                ctrl.wreg = 1'b1;
                ctrl.rn   = REG_RA;
            end

            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule : alu_ctrl_dec

// File: rtl/id_alu_ctrl_stage.sv
// ---------------------------------------------------------------------------
// id_alu_ctrl_stage
//   ID/EX pipeline register for ALU and operand-select controls. Decodes the
//   ID-stage instruction and registers the result for EX, with one cycle of
//   latency.
//
//   Handshake: id_ready = ~stall. An instruction presented with id_valid=1 is
//   accepted on a rising edge where id_ready=1 (and flush=0); while id_ready=0
//   the ID stage must hold id_inst/id_valid, and every ex_* output holds.
//   flush and rst do not affect id_ready.
//
//   Register update priority: rst > flush > stall > load. rst and flush load a
//   bubble (all outputs zero); a load with id_valid=0 also loads a bubble.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   id_valid,id_inst ID-stage instruction and its valid flag
//   stall, flush     hazard hold and redirect bubble
//   id_ready         ~stall
//   ex_*             registered EX controls (see mips_pkg::ctrl_t)
// ---------------------------------------------------------------------------
module id_alu_ctrl_stage
    import mips_pkg::*;
#(
    parameter int DW   = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [DW-1:0]   id_inst,
    input  logic            stall,
    input  logic            flush,
    output logic            id_ready,
    output logic            ex_valid,
    output logic [3:0]      ex_aluc,
    output logic            ex_shift,
    output logic [4:0]      ex_sa,
    output logic            ex_aluimm,
    output logic [DW-1:0]   ex_imm32,
    output logic            ex_wreg,
    output logic            ex_m2reg,
    output logic            ex_wmem,
    output logic [RA_W-1:0] ex_rn,
    output logic [1:0]      ex_branch,
    output logic [1:0]      ex_jump,
    output logic            ex_illegal
);

    ctrl_t dec_ctrl;
    ctrl_t load_ctrl;
    ctrl_t ex_q;
    logic  ex_valid_q;

    alu_ctrl_dec u_dec (
        .inst (id_inst),
        .ctrl (dec_ctrl)
    );

    // Illegal instructions must not leave any architectural side effect, and
    // writes to $0 are dropped here so that nop (sll $0,$0,0) never writes.
    always_comb begin
        load_ctrl = dec_ctrl;
        if (dec_ctrl.illegal) begin
            load_ctrl.wreg   = 1'b0;
            load_ctrl.wmem   = 1'b0;
            load_ctrl.m2reg  = 1'b0;
            load_ctrl.branch = BR_NONE;
            load_ctrl.jump   = JMP_NONE;
            load_ctrl.aluc   = ALU_ADD;
        end
        if (dec_ctrl.rn == 5'd0) begin
            load_ctrl.wreg = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else if (flush) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else if (!stall) begin
            if (id_valid) begin
                ex_q       <= load_ctrl;
                ex_valid_q <= 1'b1;
            end else begin
                ex_q       <= '0;
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign id_ready   = ~stall;

    assign ex_valid   = ex_valid_q;
    assign ex_aluc    = ex_q.aluc;
    assign ex_shift   = ex_q.shift;
    assign ex_sa      = ex_q.sa;
    assign ex_aluimm  = ex_q.aluimm;
    assign ex_imm32   = ex_q.imm32;
    assign ex_wreg    = ex_q.wreg;
    assign ex_m2reg   = ex_q.m2reg;
    assign ex_wmem    = ex_q.wmem;
    assign ex_rn      = ex_q.rn;
    assign ex_branch  = ex_q.branch;
    assign ex_jump    = ex_q.jump;
    assign ex_illegal = ex_q.illegal;

endmodule : id_alu_ctrl_stage

// File: doc/id_alu_ctrl_stage.md
Name: id_alu_ctrl_stage

Overview:
- Decode-side producer of the 4-bit ALU control code and operand-select controls, registered into the ID/EX pipeline boundary of the pipelined MIPS32 core.
- Takes the raw ID-stage instruction and produces registered EX controls: aluc, shift/immediate selects, write-back/memory enables, destination register, extended immediate.
- Supports stall (hold), flush (bubble) and an illegal-instruction flag.

Parameters:
- DW, 32, datapath/instruction width (fixed 32; only 32 is supported).
- RA_W, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_inst  in  32  instruction word
- stall  in  1  hold ID/EX contents (hazard unit)
- flush  in  1  replace ID/EX contents with bubble (branch/jump redirect)
- id_ready  out  1  combinational = ~stall
- ex_valid  out  1  EX slot holds an instruction
- ex_aluc  out  4  ALU control code
- ex_shift  out  1  ALU a-operand = {27'b0, ex_sa}
- ex_sa  out  5  shift amount, inst[10:6]
- ex_aluimm  out  1  ALU b-operand = ex_imm32
- ex_imm32  out  32  extended immediate
- ex_wreg  out  1  register-file write enable
- ex_m2reg  out  1  write-back from memory
- ex_wmem  out  1  memory write enable
- ex_rn  out  5  destination register
- ex_branch  out  2  01 beq, 10 bne, 00 none
- ex_jump  out  2  01 j, 10 jal, 11 jr, 00 none
- ex_illegal  out  1  unsupported opcode/funct

Behaviour:
- aluc codes: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
- R-type (op 000000), rn = rd:
  - add/addu (100000/100001) -> ADD; sub/subu (100010/100011) -> SUB.
  - and/or/xor (100100/100101/100110) -> AND/OR/XOR.
  - sll/srl/sra (000000/000010/000011) -> SLL/SRL/SRA, with ex_shift=1.
  - jr (001000) -> ex_jump=11, wreg=0.
- I-type, rn = rt, aluimm=1:
  - addi/addiu (001000/001001) -> ADD, sign-extended immediate.
  - andi/ori/xori (001100/001101/001110) -> AND/OR/XOR, zero-extended immediate.
  - lui (001111) -> LUI, zero-extended immediate.
  - lw (100011) -> ADD, sign-ext, m2reg=1.
  - sw (101011) -> ADD, sign-ext, wmem=1, wreg=0.
- Branches: beq/bne (000100/000101) -> SUB, aluimm=0, sign-ext, wreg=0, ex_branch set.
- Jumps:
  - j (000010) -> ex_jump=01, no writes.
  - jal (000011) -> ex_jump=10, wreg=1, rn=31, aluc ADD.
- Write suppression: ex_wreg forced 0 when the decoded rn==0, so nop 0x00000000 yields wreg=0.
- Illegal opcode/funct: ex_illegal=1; wreg, wmem, m2reg, branch, jump forced 0; aluc ADD; ex_valid follows id_valid.
- Don't-care controls (shift, aluimm) are 0 for non-applicable instructions.
- Register update, priority rst > flush > stall > load:
  - rst: all outputs 0 (ex_valid 0, ex_aluc 0000, ex_imm32 0).
  - flush: bubble; all outputs 0, next cycle.
  - stall (no flush): every ex_* holds its value.
  - otherwise: load decode of id_inst if id_valid; if id_valid=0, load bubble.
- Latency: one cycle from id_inst to ex_* outputs.
- Simultaneous flush+stall: flush wins.
- Reset asserted mid-stall clears state; first post-reset load needs stall=0.
- id_ready is independent of flush and rst.

Decomposition:
- Shared package mips_pkg: aluc localparams (ALU_ADD..ALU_SRA), opcode/funct constants, branch/jump encodings. The ALU consumes the same aluc constants.
- One sub-module, alu_ctrl_dec: purely combinational decode of id_inst to control bundle.
- Top: registers, priority logic, write/rn gating.

Test Plan:
- 0x00221820 (add $3,$1,$2), id_valid=1 -> next cycle aluc 0000, wreg 1, rn 3, aluimm 0, shift 0, ex_valid 1.
- 0x34058000 (ori $5,$0,0x8000) -> aluc 0101, aluimm 1, imm32 0x00008000, rn 5; then 0x8C24FFFC (lw $4,-4($1)) -> aluc 0000, imm32 0xFFFFFFFC, m2reg 1, rn 4.
- 0x00031103 (sra $2,$3,4) -> aluc 1111, shift 1, sa 4, rn 2; 0x00000000 -> wreg 0, ex_valid 1.
- Load add, then stall=1 for 3 cycles while id_inst changes -> outputs unchanged; assert flush with stall -> all outputs 0 next cycle.
- Opcode 111111 -> ex_illegal 1, wreg 0, wmem 0; 0x0C000010 (jal) -> ex_jump 10, wreg 1, rn 31.
- rst=1 for one cycle during valid stream -> all outputs 0 next cycle; id_valid=0 load -> ex_valid 0.
